// File: rtl/conv_pkg.sv
// Shared constants for the convolution display interface and the result collector FSM.
// Display-state codes match top.display_current_state; engine indices select bank rows.
package conv_pkg;

    localparam logic [2:0] DS_IDLE        = 3'd0;
    localparam logic [2:0] DS_RUN_SINGLE  = 3'd1;
    localparam logic [2:0] DS_RUN_SYS3    = 3'd2;
    localparam logic [2:0] DS_RUN_SYS2    = 3'd3;
    localparam logic [2:0] DS_SHOW_SINGLE = 3'd4;
    localparam logic [2:0] DS_SHOW_SYS3   = 3'd5;
    localparam logic [2:0] DS_SHOW_SYS2   = 3'd6;
    localparam logic [2:0] DS_FINISH      = 3'd7;

    localparam int N_ENG      = 3;
    localparam int ENG_SINGLE = 0;
    localparam int ENG_SYS3   = 1;
    localparam int ENG_SYS2   = 2;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t S_IDLE    = 2'd0;
    localparam fsm_state_t S_COLLECT = 2'd1;
    localparam fsm_state_t S_CHECK   = 2'd2;
    localparam fsm_state_t S_DONE    = 2'd3;

    // True for the three SHOW_* states that carry a result element.
    function automatic logic is_show(input logic [2:0] st);
        return (st >= DS_SHOW_SINGLE) && (st <= DS_SHOW_SYS2);
    endfunction

endpackage

// File: rtl/conv_bank_cmp.sv
// Combinational element-wise compare of two result rows.
// Only positions marked valid in both rows take part in the compare.
module conv_bank_cmp #(
    parameter int DATA_W = 8,
    parameter int N_ELEM = 4
) (
    input  logic [N_ELEM-1:0][DATA_W-1:0] ref_data,
    input  logic [N_ELEM-1:0][DATA_W-1:0] cmp_data,
    input  logic [N_ELEM-1:0]             ref_vld,
    input  logic [N_ELEM-1:0]             cmp_vld,
    output logic                          differ
);

    always_comb begin
        differ = 1'b0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (ref_vld[i] && cmp_vld[i] && (ref_data[i] != cmp_data[i]))
                differ = 1'b1;
        end
    end

endmodule

// File: rtl/conv_result_collector.sv
// Captures the serialized 2x2 results of the three convolution engines into a 12-entry bank.
// Optional build macro CONV_COLLECT_CHECK_EN adds the systolic-vs-single cross-check.
import conv_pkg::*;

module conv_result_collector #(
    parameter int DATA_W = 8,
    parameter int N_ELEM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] result_in,
    input  logic [2:0]        state_in,
    input  logic              ack,
    input  logic [3:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              incomplete,
    output logic              overflow,
    output logic [1:0]        mismatch,
    output logic [3:0]        count
);

    localparam int N_SLOT = N_ENG * N_ELEM;
    localparam int CW     = $clog2(N_ELEM + 1);

    fsm_state_t                        state;
    logic                              run_q;
    logic [N_SLOT-1:0][DATA_W-1:0]     bank;
    logic [N_ENG-1:0][CW-1:0]          elem_cnt;
    logic [3:0]                        count_q;
    logic                              incomplete_q;
    logic                              overflow_q;

    logic                              run_edge;
    logic                              cap;
    logic [1:0]                        eng;
    logic                              eng_full;
    logic                              all_full;

    assign run_edge = run & ~run_q;
    assign cap      = (state == S_COLLECT) && is_show(state_in);
    assign eng      = state_in[1:0];

    always_comb begin
        eng_full = 1'b0;
        all_full = 1'b1;
        for (int e = 0; e < N_ENG; e++) begin
            if (eng == 2'(e) && elem_cnt[e] == CW'(N_ELEM))
                eng_full = 1'b1;
            if (elem_cnt[e] != CW'(N_ELEM))
                all_full = 1'b0;
        end
    end

    // A run edge restarts collection from any state and outranks capture and ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            run_q        <= 1'b0;
            bank         <= '0;
            elem_cnt     <= '0;
            count_q      <= '0;
            incomplete_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            run_q <= run;
            if (run_edge) begin
                state        <= S_COLLECT;
                bank         <= '0;
                elem_cnt     <= '0;
                count_q      <= '0;
                incomplete_q <= 1'b0;
                overflow_q   <= 1'b0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        if (cap && eng_full)
                            overflow_q <= 1'b1;
                        for (int e = 0; e < N_ENG; e++) begin
                            for (int i = 0; i < N_ELEM; i++) begin
                                if (cap && !eng_full && eng == 2'(e) && elem_cnt[e] == CW'(i)) begin
                                    bank[e*N_ELEM + i] <= result_in;
                                    elem_cnt[e]        <= elem_cnt[e] + CW'(1);
                                end
                            end
                        end
                        if (cap && !eng_full && count_q != 4'hF)
                            count_q <= count_q + 4'd1;
                        if (all_full) begin
                            state <= S_CHECK;
                        end else if (state_in == DS_FINISH) begin
                            state <= S_CHECK;
                            if (count_q < 4'(N_SLOT))
                                incomplete_q <= 1'b1;
                        end
                    end
                    S_CHECK: state <= S_DONE;
                    S_DONE:  if (ack) state <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

`ifdef CONV_COLLECT_CHECK_EN
    logic [N_ENG-1:0][N_ELEM-1:0] vld;
    logic [1:0]                   mismatch_nxt;
    logic [1:0]                   mismatch_q;

    // Element i of a row is valid once that engine has captured more than i samples.
    always_comb begin
        vld = '0;
        for (int e = 0; e < N_ENG; e++)
            for (int i = 0; i < N_ELEM; i++)
                vld[e][i] = CW'(i) < elem_cnt[e];
    end

    conv_bank_cmp #(.DATA_W(DATA_W), .N_ELEM(N_ELEM)) u_cmp_sys3 (
        .ref_data (bank[ENG_SINGLE*N_ELEM +: N_ELEM]),
        .cmp_data (bank[ENG_SYS3*N_ELEM +: N_ELEM]),
        .ref_vld  (vld[ENG_SINGLE]),
        .cmp_vld  (vld[ENG_SYS3]),
        .differ   (mismatch_nxt[0])
    );

    conv_bank_cmp #(.DATA_W(DATA_W), .N_ELEM(N_ELEM)) u_cmp_sys2 (
        .ref_data (bank[ENG_SINGLE*N_ELEM +: N_ELEM]),
        .cmp_data (bank[ENG_SYS2*N_ELEM +: N_ELEM]),
        .ref_vld  (vld[ENG_SINGLE]),
        .cmp_vld  (vld[ENG_SYS2]),
        .differ   (mismatch_nxt[1])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mismatch_q <= 2'b00;
        else if (run_edge)
            mismatch_q <= 2'b00;
        else if (state == S_CHECK)
            mismatch_q <= mismatch_nxt;
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 2'b00;
`endif

    always_comb begin
        rd_data = '0;
        if (rd_sel < 4'(N_SLOT))
            rd_data = bank[rd_sel];
    end

    assign done       = (state == S_DONE);
    assign incomplete = incomplete_q;
    assign overflow   = overflow_q;
    assign count      = count_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Scoreboard bench for conv_result_collector: stimulus pushes expected outcomes from a
// queue-based reference model, a monitor pops and compares each time done rises.
`timescale 1ns/1ps
module tb_conv_result_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [7:0] result_in = 8'd0;
    logic [2:0] state_in = 3'd0;
    logic       ack = 1'b0;
    logic [3:0] rd_sel = 4'd0;
    logic [7:0] rd_data;
    logic       done;
    logic       incomplete;
    logic       overflow;
    logic [1:0] mismatch;
    logic [3:0] count;

    conv_result_collector #(.DATA_W(8), .N_ELEM(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .result_in  (result_in),
        .state_in   (state_in),
        .ack        (ack),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .done       (done),
        .incomplete (incomplete),
        .overflow   (overflow),
        .mismatch   (mismatch),
        .count      (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       count;
        bit       inc;
        bit       ovf;
        bit [1:0] mm;
        bit [7:0] bank[12];
        int       done_edge;
    } exp_t;

    exp_t     sb[$];
    int       checks = 0;
    int       failures = 0;

    bit [7:0] vals[12];
    bit [2:0] s_st[$];
    bit [7:0] s_val[$];
    int       s_edge[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // First n elements of the single/sys3/sys2 stream; optionally a fifth sample for one engine.
    task automatic build(input int n, input int extra_eng);
        s_st.delete();
        s_val.delete();
        for (int i = 0; i < n; i++) begin
            s_st.push_back(3'(4 + i / 4));
            s_val.push_back(vals[i]);
            if (extra_eng >= 0 && i == extra_eng * 4 + 3) begin
                s_st.push_back(3'(4 + extra_eng));
                s_val.push_back(8'($urandom_range(0, 255)));
            end
        end
    endtask

    // Reference: per-engine lists fill up to 4, extras flag overflow, compares use common prefix.
    task automatic model(input int fin_edge);
        exp_t     e;
        bit [7:0] m[3][4];
        int       sz[3];
        int       lim;
        for (int g = 0; g < 3; g++) begin
            sz[g] = 0;
            for (int i = 0; i < 4; i++) m[g][i] = 8'd0;
        end
        e.ovf = 1'b0;
        e.done_edge = -1;
        foreach (s_st[i]) begin
            int g;
            g = int'(s_st[i]) - 4;
            if (sz[g] == 4) e.ovf = 1'b1;
            else begin
                m[g][sz[g]] = s_val[i];
                sz[g]++;
            end
            if (e.done_edge < 0 && sz[0] == 4 && sz[1] == 4 && sz[2] == 4)
                e.done_edge = s_edge[i] + 2;
        end
        if (e.done_edge < 0) e.done_edge = fin_edge + 1;
        e.count = sz[0] + sz[1] + sz[2];
        e.inc   = (e.count < 12);
        e.mm    = 2'b00;
`ifdef CONV_COLLECT_CHECK_EN
        for (int k = 1; k < 3; k++) begin
            lim = (sz[0] < sz[k]) ? sz[0] : sz[k];
            for (int i = 0; i < lim; i++)
                if (m[0][i] != m[k][i]) e.mm[k-1] = 1'b1;
        end
`else
        lim = 0;
`endif
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 4; i++)
                e.bank[g*4 + i] = m[g][i];
        sb.push_back(e);
    endtask

    task automatic play(input bit fin, input bit start);
        int fin_edge;
        fin_edge = -1;
        s_edge.delete();
        if (start) begin
            @(negedge clk); run = 1'b0; state_in = 3'd0;
            @(negedge clk); run = 1'b1;
        end
        foreach (s_st[i]) begin
            @(negedge clk);
            state_in  = s_st[i];
            result_in = s_val[i];
            s_edge.push_back(cyc + 1);
        end
        if (fin) begin
            @(negedge clk);
            state_in = 3'd7;
            fin_edge = cyc + 1;
        end
        model(fin_edge);
        @(negedge clk);
        state_in  = 3'd0;
        result_in = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done=0 expected 1 within 40 cycles");
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
    endtask

    task automatic do_ack();
        int c;
        repeat (3) @(negedge clk);
        c = int'(count);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("done_cleared_by_ack", done, 0);
        chk("count_kept_after_ack", count, c);
    endtask

    task automatic std_vals();
        for (int g = 0; g < 3; g++) begin
            vals[g*4 + 0] = 8'd111;
            vals[g*4 + 1] = 8'd99;
            vals[g*4 + 2] = 8'd105;
            vals[g*4 + 3] = 8'd146;
        end
    endtask

    // Monitor: on each done rising edge, check latency, flags and the whole read port.
    initial begin
        bit prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done=1 with no expected result queued");
                end else begin
                    e = sb.pop_front();
                    chk("done_latency_edge", cyc, e.done_edge);
                    chk("count", count, e.count);
                    chk("incomplete", incomplete, e.inc);
                    chk("overflow", overflow, e.ovf);
                    chk("mismatch", mismatch, e.mm);
                    for (int i = 0; i < 16; i++) begin
                        rd_sel = 4'(i);
                        #1;
                        chk($sformatf("rd_data[%0d]", i), rd_data, (i < 12) ? e.bank[i] : 0);
                    end
                end
            end
            prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_done", done, 0);
        chk("reset_count", count, 0);
        chk("reset_incomplete", incomplete, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_mismatch", mismatch, 0);
        chk("reset_rd_data", rd_data, 0);
        @(negedge clk); reset = 1'b1;

        // full stream
        std_vals(); build(12, -1); play(1'b0, 1'b1); wait_done(); do_ack();
        // systolic2 c22 corrupted
        std_vals(); vals[11] = 8'd145; build(12, -1); play(1'b0, 1'b1); wait_done(); do_ack();
        // early finish after 9 samples
        std_vals(); build(9, -1); play(1'b1, 1'b1); wait_done(); do_ack();
        // five samples for systolic3
        std_vals(); build(12, 1); play(1'b0, 1'b1); wait_done(); do_ack();

        // reset after 6 captures, then a clean run
        std_vals(); build(6, -1);
        @(negedge clk); run = 1'b0;
        @(negedge clk); run = 1'b1;
        foreach (s_st[i]) begin
            @(negedge clk); state_in = s_st[i]; result_in = s_val[i];
        end
        @(negedge clk);
        state_in = 3'd0;
        chk("count_before_reset", count, 6);
        reset = 1'b0;
        #1;
        chk("midreset_count", count, 0);
        chk("midreset_done", done, 0);
        chk("midreset_overflow", overflow, 0);
        chk("midreset_incomplete", incomplete, 0);
        @(negedge clk); reset = 1'b1; run = 1'b0;
        build(12, -1); play(1'b0, 1'b1); wait_done(); do_ack();

        // run edge while done, ack high in the same cycle
        std_vals(); build(12, -1); play(1'b0, 1'b1); wait_done();
        repeat (3) @(negedge clk);
        run = 1'b0;
        @(negedge clk); run = 1'b1; ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("rerun_done_low", done, 0);
        chk("rerun_count_zero", count, 0);
        play(1'b0, 1'b0); wait_done(); do_ack();

        // randomized scenarios
        for (int r = 0; r < 12; r++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 12; i++) vals[i] = 8'($urandom_range(0, 255));
            if (mode == 0) begin
                for (int i = 0; i < 4; i++) begin
                    vals[4 + i] = vals[i];
                    vals[8 + i] = vals[i];
                end
                if ($urandom_range(0, 1) == 1)
                    vals[$urandom_range(4, 11)] ^= 8'(1 << $urandom_range(0, 7));
                build(12, -1); play(1'b0, 1'b1);
            end else if (mode == 1) begin
                build(int'($urandom_range(1, 11)), -1); play(1'b1, 1'b1);
            end else begin
                build(12, int'($urandom_range(0, 1))); play(1'b0, 1'b1);
            end
            wait_done(); do_ack();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Sink for the serialized result stream of the convolution `top`, which drives `display_result` and `display_current_state`. It sits downstream of `top`, on that display interface:
- captures the four 2x2 outputs from each of the three engines (single MAC, systolic3, systolic2) into a 12-entry bank;
- raises `done` when capture is complete;
- optionally cross-checks both systolic banks against the single-MAC bank.

## Interface
Parameters:
- DATA_W, 8, width of one result element
- N_ELEM, 4, elements per engine (c11, c12, c21, c22)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  same `run` that drives `top`; a 0->1 edge starts a new collection
- result_in  in  DATA_W  from `top.display_result`
- state_in  in  3  from `top.display_current_state`
- ack  in  1  consumer acknowledge; clears `done`
- rd_sel  in  4  read index, engine*4 + element (0..11)
- rd_data  out  DATA_W  bank entry at rd_sel (combinational read)
- done  out  1  collection finished, held until ack or a new run edge
- incomplete  out  1  stream ended before 12 samples
- overflow  out  1  more than N_ELEM samples seen for one engine
- mismatch  out  2  bit0: systolic3 bank differs from single; bit1: systolic2 bank differs from single
- count  out  4  samples captured so far

## Operation
- `state_in` encoding (shared package):
  - 0 IDLE, 1 RUN_SINGLE, 2 RUN_SYS3, 3 RUN_SYS2
  - 4 SHOW_SINGLE, 5 SHOW_SYS3, 6 SHOW_SYS2, 7 FINISH
- FSM states are S_IDLE, S_COLLECT, S_CHECK and S_DONE.
- S_IDLE -> S_COLLECT on a run rising edge (run registered, edge = run & ~run_q).
  - Entry clears the bank, all per-engine element counters, count and all flags.
- In S_COLLECT, each cycle with state_in in 4..6 is a capture:
  - engine = state_in-4;
  - result_in is written to bank[engine*4 + elem_cnt[engine]];
  - elem_cnt[engine] and count increment.
- Capture when elem_cnt[engine] == N_ELEM:
  - the write is dropped and `overflow` is set (sticky);
  - count does not change.
- S_COLLECT -> S_CHECK when:
  - all three elem_cnt equal N_ELEM, or
  - state_in == 7. If count < 12 at that point, `incomplete` is set.
- S_CHECK takes one cycle. It computes `mismatch` by element-wise compare.
  - Under `incomplete`, only the positions captured in both compared banks are compared.
- S_CHECK -> S_DONE; `done`=1.
- S_DONE -> S_IDLE on ack=1. done drops; the bank, flags and count stay readable.
- A run rising edge in any state, including S_DONE, has the same effect as S_IDLE entry: clear and go to S_COLLECT. It takes priority over ack.
- Arithmetic: counters saturate and never wrap; bank entries are stored unmodified, with no sign handling.
- rd_sel > 11 reads 0.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - FSM S_IDLE;
  - done=0, incomplete=0, overflow=0, mismatch=0, count=0;
  - bank=0, so rd_data=0.
- Capture: result_in/state_in are sampled on rising edge N, and count is updated after edge N.
- 12 back-to-back display cycles finish as follows:
  - last capture at edge N;
  - S_CHECK at edge N+1;
  - done=1 after edge N+2.
- A capture and the run edge in the same cycle: the clear wins and the sample is discarded.
- ack in the same cycle as S_CHECK is ignored; only ack seen in S_DONE counts.
- Reset mid-collection aborts immediately. Captured data is not preserved.

## Configuration
- `CONV_COLLECT_CHECK_EN` defined: the S_CHECK compare logic is built, and mismatch is reported as described above.
- Not defined:
  - the comparators are removed and mismatch is tied to 2'b00;
  - S_CHECK is still one cycle, so latency is identical in both builds.

## Structure
- Package `conv_pkg` holds:
  - the 3-bit display-state localparams (0..7);
  - the engine index constants (ENG_SINGLE=0, ENG_SYS3=1, ENG_SYS2=2);
  - the FSM state typedef;
  - N_ENG=3.
- One sub-module, `conv_bank_cmp`: a combinational 4-element compare with valid masks. It is instantiated twice, and only under `CONV_COLLECT_CHECK_EN`.

## Test plan
1. Stimulus used in scenarios 1-6:
   - A rows: 3 1 6 5 / 7 5 2 7 / 7 10 8 9 / 1 3 2 10;
   - B rows: 3 1 4 / 0 5 1 / 0 1 5;
   - result stream: 111, 99, 105, 146 repeated in states 4, 5, 6.

   Drive that stream for 12 cycles, preceded by a run edge. Required: done=1 two cycles after the last capture; count=12; mismatch=0; rd_sel=0..11 returns the stream.
2. Same stream with the systolic2 c22 entry changed to 145 -> mismatch=2'b10, done=1, and rd_sel=11 reads 145.
3. state_in goes to 7 after 9 samples -> incomplete=1, count=9, done=1, mismatch=0.
4. Five samples in state 5 -> overflow=1; the fifth value does not appear at any rd_sel; count=12 after the full stream.
5. Reset pulsed low after 6 captures -> all outputs 0 immediately. A new run edge plus the full stream completes normally.
6. run edge while done=1, ack held high the same cycle -> FSM re-enters S_COLLECT with count=0. With the macro undefined, scenario 2 gives mismatch=0 at the same latency.
